// File: rtl/sram_pkg.sv
// Shared types and width helpers for the pipelined line SRAM.
// Default geometry matches the cache data/tag array it replaces.
package sram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

   localparam int SRAM_DATA_WIDTH = 256;
   localparam int SRAM_WORD_WIDTH = 32;
   localparam int SRAM_DEPTH      = 32;
   localparam int SRAM_WORDS      = SRAM_DATA_WIDTH / SRAM_WORD_WIDTH;
   localparam int SRAM_IDX_W      = clog2(SRAM_DEPTH);

endpackage

// File: rtl/sram_read_pipe.sv
// Read-data delay line: READ_LATENCY register stages, each carrying a valid bit.
// Data stages only load on a valid, so the output holds its last read value.
module sram_read_pipe #(
   parameter int READ_LATENCY = 1,
   parameter int DATA_WIDTH   = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  vld [READ_LATENCY];
   logic [DATA_WIDTH-1:0] dat [READ_LATENCY];

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            vld[i] <= 1'b0;
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[READ_LATENCY-1];
   assign out_data  = dat[READ_LATENCY-1];

endmodule

// File: rtl/sram_pipe.sv
// Line SRAM with valid/ready requests, per-word write masking, 1- or 2-cycle
// registered reads and a zero-clear sequencer that runs after reset or on clear_i.
module sram_pipe
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 7,
   parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
   parameter int WORD_WIDTH   = SRAM_WORD_WIDTH,
   parameter int DEPTH        = SRAM_DEPTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_i,
   input  logic                             we_i,
   input  logic [ADDR_WIDTH-1:0]            addr_i,
   input  logic [DATA_WIDTH/WORD_WIDTH-1:0] wmask_i,
   input  logic [DATA_WIDTH-1:0]            data_i,
   input  logic                             clear_i,
   output logic                             ready_o,
   output logic [DATA_WIDTH-1:0]            data_o,
   output logic                             valid_o,
   output logic                             init_done_o
);

   localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
   localparam int IDX_W = clog2(DEPTH);

   state_e                state;
   logic [IDX_W-1:0]      clr_idx;
   logic [IDX_W-1:0]      idx;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  unused_addr_bits;

   // Byte address to line index; byte-offset and high bits alias.
   assign idx              = addr_i[IDX_W+1:2];
   assign unused_addr_bits = ^{addr_i[1:0], addr_i >> (IDX_W + 2)};

   assign ready_o     = (state == IDLE) && !clear_i;
   assign init_done_o = (state == IDLE);
   assign wr_acc      = req_i && ready_o && we_i;
   assign rd_acc      = req_i && ready_o && !we_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= INIT;
         clr_idx <= '0;
      end else begin
         case (state)
            INIT: begin
               if (clear_i) begin
                  clr_idx <= '0;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
                  if (clr_idx == IDX_W'(DEPTH - 1)) state <= IDLE;
               end
            end
            IDLE: begin
               if (clear_i) begin
                  state   <= INIT;
                  clr_idx <= '0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   // NOTE: every variable assigned in always_comb gets a full default first, so no latch is inferred.
   always_comb begin
      merged = mem[idx];
      for (int w = 0; w < WORDS; w++) begin
         if (wmask_i[w]) merged[w*WORD_WIDTH +: WORD_WIDTH] = data_i[w*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   // NOTE: the array has no reset; its contents are zeroed by the INIT sequence instead.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[clr_idx] <= '0;
      end else if (wr_acc) begin
         mem[idx] <= merged;
      end
   end

   sram_read_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_read_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_acc),
      .in_data   (mem[idx]),
      .out_valid (valid_o),
      .out_data  (data_o)
   );

endmodule

// File: tb/tb_sram_pipe.sv
// Randomised bench for sram_pipe: latency-1 and latency-2 instances share stimulus
// and are checked against an array model with per-instance read-return queues.
module tb_sram_pipe;

   localparam int AW    = 7;
   localparam int DW    = 256;
   localparam int WW    = 32;
   localparam int NW    = DW / WW;
   localparam int DEPTH = 32;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_t;

   logic          clk;
   logic          rst_n;
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [NW-1:0] wmask;
   logic [DW-1:0] wdata;
   logic          clr;

   logic          ready1, valid1, done1;
   logic          ready2, valid2, done2;
   logic [DW-1:0] data1, data2;

   logic [DW-1:0] m_mem [DEPTH];
   rd_t           q1[$];
   rd_t           q2[$];
   logic [DW-1:0] last1, last2;
   int            init_left;
   int            cyc;
   int            n_vec;
   int            n_err;

   sram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wmask_i(wmask),
      .data_i(wdata), .clear_i(clr), .ready_o(ready1), .data_o(data1), .valid_o(valid1),
      .init_done_o(done1)
   );

   sram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wmask_i(wmask),
      .data_i(wdata), .clear_i(clr), .ready_o(ready2), .data_o(data2), .valid_o(valid2),
      .init_done_o(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
   endtask

   // Compare read-return outputs against what each latency's queue says is due now.
   task automatic check_outputs();
      logic ev1, ev2;
      ev1 = (q1.size() > 0) && (q1[0].due == cyc);
      ev2 = (q2.size() > 0) && (q2[0].due == cyc);
      if (ev1) begin last1 = q1[0].data; void'(q1.pop_front()); end
      if (ev2) begin last2 = q2[0].data; void'(q2.pop_front()); end
      check("valid_l1", valid1, ev1);
      check("data_l1",  data1,  last1);
      check("valid_l2", valid2, ev2);
      check("data_l2",  data2,  last2);
   endtask

   task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [NW-1:0] m, input logic [DW-1:0] d, input logic c);
      logic exp_rdy, acc;
      int   li;
      @(negedge clk);
      check_outputs();
      req = r; we = w; addr = a; wmask = m; wdata = d; clr = c;
      #1;
      exp_rdy = (init_left == 0) && !c;
      check("ready_l1", ready1, exp_rdy);
      check("ready_l2", ready2, exp_rdy);
      check("init_done_l1", done1, init_left == 0);
      check("init_done_l2", done2, init_left == 0);
      acc = r && exp_rdy;
      li  = (int'(a) >> 2) % DEPTH;
      if (acc && !w) begin
         q1.push_back('{due: cyc + 1, data: m_mem[li]});
         q2.push_back('{due: cyc + 2, data: m_mem[li]});
      end
      @(posedge clk);
      cyc++;
      if (c) begin
         init_left = DEPTH;
         clear_model();
      end else if (init_left > 0) begin
         init_left--;
      end else if (acc && w) begin
         for (int k = 0; k < NW; k++)
            if (m[k]) m_mem[li][k*WW +: WW] = d[k*WW +: WW];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cycle(1'b1, 1'b0, a, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] m, input logic [DW-1:0] d);
      cycle(1'b1, 1'b1, a, m, d, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wmask = '0; wdata = '0; clr = 1'b0;
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      #1;
      check("rst_valid_l1", valid1, 1'b0);
      check("rst_valid_l2", valid2, 1'b0);
      check("rst_data_l1",  data1,  '0);
      check("rst_data_l2",  data2,  '0);
      check("rst_ready_l1", ready1, 1'b0);
      check("rst_ready_l2", ready2, 1'b0);
      check("rst_done_l1",  done1,  1'b0);
      check("rst_done_l2",  done2,  1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hold_valid_l2", valid2, 1'b0);
      check("rst_hold_data_l2",  data2,  '0);
      rst_n = 1'b1;
      init_left = DEPTH;
      clear_model();
      @(posedge clk);
      cyc++;
      init_left--;
   endtask

   initial begin
      logic [DW-1:0] ones, a5, rdat;
      n_vec = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wmask = '0; wdata = '0; clr = 1'b0;
      last1 = '0; last2 = '0;
      init_left = DEPTH;
      clear_model();
      ones = '1;
      a5   = {(DW/8){8'hA5}};

      // Power-up clear: ready stays low for the whole INIT sequence.
      apply_reset();
      idle(DEPTH - 1);
      rd(7'h00); rd(7'h14); rd(7'h7C);

      // Masked write keeps words 1 and 3..7.
      wr(7'h14, 8'b0000_0101, ones);
      rd(7'h14);

      rd(7'h00); rd(7'h04); rd(7'h08);

      // Write then immediate read of the same line.
      wr(7'h0C, '1, a5);
      rd(7'h0C);

      // Clear with a read in flight; the request in the clear cycle is refused.
      rd(7'h0C);
      cycle(1'b1, 1'b1, 7'h0C, '1, ones, 1'b1);
      idle(DEPTH);
      rd(7'h0C);
      rd(7'h14);
      idle(3);

      // Reset with a latency-2 read in flight drops it.
      wr(7'h10, '1, {8{32'h1234_5678}});
      rd(7'h10);
      rd(7'h10);
      apply_reset();
      idle(DEPTH + 2);

      for (int i = 0; i < 500; i++) begin
         rdat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (i == 250) begin
            apply_reset();
         end else begin
            cycle(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 127)), NW'($urandom_range(0, 255)), rdat,
                  ($urandom_range(0, 119) == 0));
         end
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
